// File: rtl/noc_flit_serializer.sv
// rtl/noc_flit_serializer.sv - packet header + payload stream to registered head/tail flit stream
// One flit register feeds the output; headers and payload words load it directly, one per cycle.
module noc_flit_serializer #(
  parameter int DATA_WIDTH         = 64,
  parameter int MAX_PAYLOAD_LENGTH = 8,
  parameter int LENGTH_WIDTH       = $clog2(MAX_PAYLOAD_LENGTH + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_header_valid,
  output logic                    o_header_ready,
  input  logic [DATA_WIDTH-1:0]   i_header,
  input  logic [LENGTH_WIDTH-1:0] i_payload_length,
  input  logic                    i_payload_valid,
  output logic                    o_payload_ready,
  input  logic [DATA_WIDTH-1:0]   i_payload_data,
  output logic                    o_flit_out_valid,
  input  logic                    i_flit_out_ready,
  output logic                    o_flit_out_head,
  output logic                    o_flit_out_tail,
  output logic [DATA_WIDTH-1:0]   o_flit_out_data
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PAYLOAD = 1'b1
  } state_t;

  localparam logic [LENGTH_WIDTH-1:0] MAX_LEN = LENGTH_WIDTH'(MAX_PAYLOAD_LENGTH);
  localparam logic [LENGTH_WIDTH-1:0] ONE_LEN = LENGTH_WIDTH'(1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [LENGTH_WIDTH-1:0] r_remaining;
  logic [LENGTH_WIDTH-1:0] w_remaining_next;

  logic                    r_valid;
  logic                    r_head;
  logic                    r_tail;
  logic [DATA_WIDTH-1:0]   r_data;

  logic                    w_load_en;
  logic                    w_header_ready;
  logic                    w_payload_ready;
  logic                    w_header_acc;
  logic                    w_payload_acc;
  logic [LENGTH_WIDTH-1:0] w_sat_len;
  logic                    w_last_payload;

  // The flit register may be reloaded when empty or when its current flit leaves this cycle.
  assign w_load_en       = !r_valid || i_flit_out_ready;
  assign w_header_ready  = (r_state == S_IDLE) && w_load_en;
  assign w_payload_ready = (r_state == S_PAYLOAD) && w_load_en;
  assign w_header_acc    = i_header_valid && w_header_ready;
  assign w_payload_acc   = i_payload_valid && w_payload_ready;
  assign w_sat_len       = (i_payload_length > MAX_LEN) ? MAX_LEN : i_payload_length;
  assign w_last_payload  = (r_remaining == ONE_LEN);

  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    case (r_state)
      S_IDLE: begin
        if (w_header_acc && (i_payload_length != '0)) begin
          w_remaining_next = w_sat_len;
          w_state_next     = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (w_payload_acc) begin
          w_remaining_next = r_remaining - ONE_LEN;
          if (w_last_payload) begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next     = S_IDLE;
        w_remaining_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
    end
  end

  // Head/tail/data are left untouched on an idle load; only valid drops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_data  <= '0;
    end else if (w_load_en) begin
      if (w_header_acc) begin
        r_valid <= 1'b1;
        r_head  <= 1'b1;
        r_tail  <= (i_payload_length == '0);
        r_data  <= i_header;
      end else if (w_payload_acc) begin
        r_valid <= 1'b1;
        r_head  <= 1'b0;
        r_tail  <= w_last_payload;
        r_data  <= i_payload_data;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_header_ready   = w_header_ready;
  assign o_payload_ready  = w_payload_ready;
  assign o_flit_out_valid = r_valid;
  assign o_flit_out_head  = r_head;
  assign o_flit_out_tail  = r_tail;
  assign o_flit_out_data  = r_data;

endmodule

// File: tb/tb_noc_flit_serializer.sv
// tb/tb_noc_flit_serializer.sv - directed vector table plus reset/saturation sequences for noc_flit_serializer
module tb_noc_flit_serializer;

  localparam int DW = 64;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          header_valid;
  logic          header_ready;
  logic [DW-1:0] header;
  logic [LW-1:0] payload_length;
  logic          payload_valid;
  logic          payload_ready;
  logic [DW-1:0] payload_data;
  logic          flit_out_valid;
  logic          flit_out_ready;
  logic          flit_out_head;
  logic          flit_out_tail;
  logic [DW-1:0] flit_out_data;

  int n_checks = 0;
  int n_errors = 0;

  noc_flit_serializer #(
    .DATA_WIDTH(DW),
    .MAX_PAYLOAD_LENGTH(8)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_header_valid  (header_valid),
    .o_header_ready  (header_ready),
    .i_header        (header),
    .i_payload_length(payload_length),
    .i_payload_valid (payload_valid),
    .o_payload_ready (payload_ready),
    .i_payload_data  (payload_data),
    .o_flit_out_valid(flit_out_valid),
    .i_flit_out_ready(flit_out_ready),
    .o_flit_out_head (flit_out_head),
    .o_flit_out_tail (flit_out_tail),
    .o_flit_out_data (flit_out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          hv;
    logic [DW-1:0] hdr;
    logic [LW-1:0] len;
    logic          pv;
    logic [DW-1:0] pd;
    logic          fr;
    logic          e_hr;
    logic          e_pr;
    logic          e_v;
    logic          e_h;
    logic          e_t;
    logic [DW-1:0] e_d;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic hv, input logic [DW-1:0] hdr, input logic [LW-1:0] len,
                       input logic pv, input logic [DW-1:0] pd, input logic fr);
    header_valid   = hv;
    header         = hdr;
    payload_length = len;
    payload_valid  = pv;
    payload_data   = pd;
    flit_out_ready = fr;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic h, input logic t, input logic [DW-1:0] d);
    chk({tag, " valid"}, DW'(flit_out_valid), DW'(v));
    if (v) begin
      chk({tag, " head"}, DW'(flit_out_head), DW'(h));
      chk({tag, " tail"}, DW'(flit_out_tail), DW'(t));
      chk({tag, " data"}, flit_out_data, d);
    end
  endtask

  initial begin
    int acc_cnt;
    logic acc;

    //          hv  hdr    len  pv  pd     fr  hr  pr  v  h  t  data
    vecs[0]  = '{1, 'hA5, 0, 0, 'h00, 1, 1, 0, 1, 1, 1, 'hA5};
    vecs[1]  = '{1, 'h10, 3, 0, 'h00, 1, 1, 0, 1, 1, 0, 'h10};
    vecs[2]  = '{1, 'hEE, 0, 1, 'h11, 1, 0, 1, 1, 0, 0, 'h11};
    vecs[3]  = '{0, 'h00, 0, 1, 'h12, 1, 0, 1, 1, 0, 0, 'h12};
    vecs[4]  = '{0, 'h00, 0, 1, 'h13, 1, 0, 1, 1, 0, 1, 'h13};
    vecs[5]  = '{1, 'h20, 2, 1, 'hDD, 1, 1, 0, 1, 1, 0, 'h20};
    vecs[6]  = '{0, 'h00, 0, 1, 'h21, 0, 0, 0, 1, 1, 0, 'h20};
    vecs[7]  = '{0, 'h00, 0, 1, 'h21, 0, 0, 0, 1, 1, 0, 'h20};
    vecs[8]  = '{0, 'h00, 0, 1, 'h21, 0, 0, 0, 1, 1, 0, 'h20};
    vecs[9]  = '{0, 'h00, 0, 1, 'h21, 0, 0, 0, 1, 1, 0, 'h20};
    vecs[10] = '{0, 'h00, 0, 1, 'h21, 1, 0, 1, 1, 0, 0, 'h21};
    vecs[11] = '{0, 'h00, 0, 1, 'h22, 1, 0, 1, 1, 0, 1, 'h22};
    vecs[12] = '{0, 'h00, 0, 0, 'h00, 1, 1, 0, 0, 0, 0, 'h00};
    vecs[13] = '{0, 'h00, 0, 1, 'h99, 0, 1, 0, 0, 0, 0, 'h00};
    vecs[14] = '{1, 'h30, 1, 0, 'h00, 0, 1, 0, 1, 1, 0, 'h30};
    vecs[15] = '{0, 'h00, 0, 1, 'h31, 0, 0, 0, 1, 1, 0, 'h30};
    vecs[16] = '{0, 'h00, 0, 1, 'h31, 1, 0, 1, 1, 0, 1, 'h31};
    vecs[17] = '{0, 'h00, 0, 0, 'h00, 0, 0, 0, 1, 0, 1, 'h31};
    vecs[18] = '{0, 'h00, 0, 0, 'h00, 1, 1, 0, 0, 0, 0, 'h00};

    // Reset held with inputs toggling
    rst_n = 1'b0;
    drive(0, '0, '0, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(i[0], DW'(64'hF0 + i), LW'(i + 1), ~i[0], DW'(64'hE0 + i), i[0]);
      #1;
      chk("rst valid", DW'(flit_out_valid), '0);
      chk("rst data", flit_out_data, '0);
      chk("rst head", DW'(flit_out_head), '0);
      chk("rst tail", DW'(flit_out_tail), '0);
      chk("rst hready", DW'(header_ready), DW'(1));
      chk("rst pready", DW'(payload_ready), '0);
    end
    @(negedge clk);
    drive(0, '0, '0, 0, '0, 1);
    rst_n = 1'b1;

    // Vector table: readies sampled before the edge, flit register after it
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].hv, vecs[i].hdr, vecs[i].len, vecs[i].pv, vecs[i].pd, vecs[i].fr);
      #1;
      chk($sformatf("v%0d hready", i), DW'(header_ready), DW'(vecs[i].e_hr));
      chk($sformatf("v%0d pready", i), DW'(payload_ready), DW'(vecs[i].e_pr));
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i].e_v, vecs[i].e_h, vecs[i].e_t, vecs[i].e_d);
    end

    // Saturation: length 15 clamps to 8 payload flits
    @(negedge clk);
    drive(1, DW'(64'h40), LW'(15), 0, '0, 1);
    @(posedge clk);
    #1;
    chk_out("sat head", 1, 1, 0, DW'(64'h40));
    acc_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      drive(0, '0, '0, 1, DW'(64'h41 + acc_cnt), 1);
      #1;
      acc = payload_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        acc_cnt++;
        chk_out($sformatf("sat p%0d", acc_cnt), 1, 0, (acc_cnt == 8), DW'(64'h40 + acc_cnt));
      end
    end
    chk("sat count", DW'(acc_cnt), DW'(8));
    chk("sat 9th not taken valid", DW'(flit_out_valid), '0);

    // Mid-packet reset after 2 of 5 payloads
    @(negedge clk);
    drive(1, DW'(64'h50), LW'(5), 0, '0, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(0, '0, '0, 1, DW'(64'h51 + k), 1);
    end
    @(posedge clk);
    #1;
    chk_out("pre-rst p2", 1, 0, 0, DW'(64'h52));
    #2;
    drive(1, DW'(64'hBB), LW'(2), 1, DW'(64'hCC), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst valid", DW'(flit_out_valid), '0);
    chk("midrst data", flit_out_data, '0);
    chk("midrst head", DW'(flit_out_head), '0);
    chk("midrst tail", DW'(flit_out_tail), '0);
    chk("midrst hready", DW'(header_ready), DW'(1));
    chk("midrst pready", DW'(payload_ready), '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, DW'(64'h77), LW'(0), 0, '0, 1);
    #1;
    chk("post-rst hready", DW'(header_ready), DW'(1));
    @(posedge clk);
    #1;
    chk_out("post-rst flit", 1, 1, 1, DW'(64'h77));
    @(negedge clk);
    drive(0, '0, '0, 0, '0, 1);
    @(posedge clk);
    #1;
    chk_out("post-rst drain", 0, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
